// File: rtl/vga_scanout_if.sv
// Scan-out bus: VRAM read port plus the VGA connector pins.
interface vga_scanout_if;
  logic [18:0] raddr;
  logic [7:0]  data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output raddr,
    input  data,
    output vga_r,
    output vga_g,
    output vga_b,
    output hsync,
    output vsync,
    output frame_start
  );

  modport slave (
    input  raddr,
    output data,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  hsync,
    input  vsync,
    input  frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out: pixel-rate divider, h/v counters, VRAM addressing and
// registered amber RGB + syncs, all delayed by one pixel to match VRAM latency.
module vga_scanout #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanout_if.master bus
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [DIV_W-1:0]  r_div;
  logic [H_W-1:0]    r_h;
  logic [V_W-1:0]    r_v;
  logic [3:0]        r_red;
  logic [3:0]        r_green;
  logic [3:0]        r_blue;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_frame_start;

  logic              w_tick;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_active;
  logic              w_hsync_n;
  logic              w_vsync_n;
  logic [ADDR_W-1:0] w_raddr;

  assign w_tick   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_h_last = (r_h == H_W'(H_TOTAL - 1));
  assign w_v_last = (r_v == V_W'(V_TOTAL - 1));
  assign w_active = (r_h < H_W'(H_ACTIVE)) && (r_v < V_W'(V_ACTIVE));

  // Constant multiply reduces to shift-add ((v<<9)+(v<<7) for 640 columns).
  assign w_raddr = w_active ? (ADDR_W'(r_v) * ADDR_W'(H_ACTIVE) + ADDR_W'(r_h))
                            : '0;

  assign w_hsync_n = !((r_h >= H_W'(HS_FIRST)) && (r_h <= H_W'(HS_LAST)));
  assign w_vsync_n = !((r_v >= V_W'(VS_FIRST)) && (r_v <= V_W'(VS_LAST)));

  // Pixel divider and raster counters; v advances on the same tick h wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) begin
        r_h <= w_h_last ? '0 : r_h + H_W'(1);
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : r_v + V_W'(1);
        end
      end
    end
  end

  // Pins load once per pixel, carrying the pixel the counters just left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && w_h_last && w_v_last;
      if (w_tick) begin
        r_red   <= w_active ? bus.data[7:4] : 4'd0;
        r_green <= w_active ? bus.data[3:0] : 4'd0;
        r_blue  <= 4'd0;
        r_hsync <= w_hsync_n;
        r_vsync <= w_vsync_n;
      end
    end
  end

  assign bus.raddr       = w_raddr;
  assign bus.vga_r       = r_red;
  assign bus.vga_g       = r_green;
  assign bus.vga_b       = r_blue;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench: a reduced-raster instance with random VRAM content plus a
// full 640x480 instance, both checked every clock against a raster model.
module tb_vga_scanout;

  localparam int unsigned D = 4;
  localparam int unsigned SHA = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int unsigned SVA = 8,  SVF = 1, SVS = 2, SVB = 2;
  localparam int unsigned FHA = 640, FHF = 16, FHS = 96, FHB = 48;
  localparam int unsigned FVA = 480, FVF = 10, FVS = 2,  FVB = 33;
  localparam int unsigned RST_AT = 6613;
  localparam int unsigned TOTAL  = 10600;

  typedef struct packed {
    logic [31:0] raddr;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_scanout_if s_if ();
  vga_scanout_if f_if ();

  vga_scanout #(
    .CLK_DIV(D), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (.clk(clk), .rst(rst), .bus(s_if));

  vga_scanout #(.CLK_DIV(D)) u_full (.clk(clk), .rst(rst), .bus(f_if));

  bit   lit [SVA][SHA];
  exp_t q_s[$];
  exp_t q_f[$];
  int   errors = 0;
  int   checks = 0;

  // Expected pins after the k-th clock edge since reset release.
  function automatic exp_t model(int unsigned k, bit full);
    int unsigned ha = full ? FHA : SHA;
    int unsigned ht = full ? (FHA + FHF + FHS + FHB) : (SHA + SHF + SHS + SHB);
    int unsigned va = full ? FVA : SVA;
    int unsigned vt = full ? (FVA + FVF + FVS + FVB) : (SVA + SVF + SVS + SVB);
    int unsigned hsf = full ? (FHA + FHF) : (SHA + SHF);
    int unsigned hsn = full ? FHS : SHS;
    int unsigned vsf = full ? (FVA + FVF) : (SVA + SVF);
    int unsigned vsn = full ? FVS : SVS;
    int unsigned n = k / D;
    int unsigned h = n % ht;
    int unsigned v = (n / ht) % vt;
    int unsigned m, hm, vm;
    exp_t e;
    e.raddr = (h < ha && v < va) ? (v * ha + h) : 0;
    e.r = 0; e.g = 0; e.b = 0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
    if (n > 0) begin
      m  = n - 1;
      hm = m % ht;
      vm = (m / ht) % vt;
      if (hm < ha && vm < va) begin
        if (full || lit[vm][hm]) begin
          e.r = 4'hF;
          e.g = 4'hC;
        end
      end
      e.hs = !(hm >= hsf && hm < hsf + hsn);
      e.vs = !(vm >= vsf && vm < vsf + vsn);
      e.fs = (k % D == 0) && (n % (ht * vt) == 0);
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(string tag, exp_t e, logic [18:0] ra, logic [3:0] r,
                           logic [3:0] g, logic [3:0] b, logic hs, logic vs, logic fs);
    check({tag, ".raddr"}, 32'(ra), e.raddr);
    check({tag, ".vga_r"}, 32'(r), 32'(e.r));
    check({tag, ".vga_g"}, 32'(g), 32'(e.g));
    check({tag, ".vga_b"}, 32'(b), 32'(e.b));
    check({tag, ".hsync"}, 32'(hs), 32'(e.hs));
    check({tag, ".vsync"}, 32'(vs), 32'(e.vs));
    check({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  // Monitor: compare both instances against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_s.size() == 0 || q_f.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue at %0t: got empty expected entry", $time);
      end else begin
        e = q_s.pop_front();
        check_all("small", e, s_if.raddr, s_if.vga_r, s_if.vga_g, s_if.vga_b,
                  s_if.hsync, s_if.vsync, s_if.frame_start);
        e = q_f.pop_front();
        check_all("full", e, f_if.raddr, f_if.vga_r, f_if.vga_g, f_if.vga_b,
                  f_if.hsync, f_if.vsync, f_if.frame_start);
      end
    end
  end

  // Driver: reset schedule, VRAM data and expectation push once per clock.
  initial begin
    int unsigned k = 0;
    int unsigned n, h, v;
    logic        rst_edge;
    rst = 1'b1;
    s_if.data = 8'hFC;
    f_if.data = 8'hFC;
    foreach (lit[i, j]) lit[i][j] = 1'b0;
    lit[2][5] = 1'b1;
    for (int cyc = 0; cyc < int'(TOTAL); cyc++) begin
      @(posedge clk);
      rst_edge = rst;
      #1;
      if (rst_edge) k = 0;
      else k++;
      if (cyc < 3 || (cyc >= int'(RST_AT) && cyc < int'(RST_AT) + 3)) rst = 1'b1;
      else rst = 1'b0;
      if (cyc == int'(RST_AT))
        foreach (lit[i, j]) lit[i][j] = 1'($urandom_range(0, 1));
      if (rst) begin
        k = 0;
        s_if.data = 8'hFC;
      end else if ((k + 1) % D == 0) begin
        n = k / D;
        h = n % (SHA + SHF + SHS + SHB);
        v = (n / (SHA + SHF + SHS + SHB)) % (SVA + SVF + SVS + SVB);
        if (h < SHA && v < SVA) s_if.data = lit[v][h] ? 8'hFC : 8'h00;
        else s_if.data = ($urandom_range(0, 1) == 1) ? 8'hFC : 8'($urandom);
      end else begin
        s_if.data = 8'($urandom);
      end
      q_s.push_back(model(k, 1'b0));
      q_f.push_back(model(k, 1'b1));
    end
    @(negedge clk);
    #1;
    checks++;
    if (q_s.size() != 0 || q_f.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left expected 0", q_s.size(), q_f.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Scan-out stage between the 640x480 1-bit VRAM and the VGA connector. It divides the system clock down to a pixel rate and runs the 640x480@60 horizontal/vertical counters. It drives the VRAM read address and converts the 8-bit amber pixel word returned one clock later into 4-bit R/G/B, with syncs and blanking aligned to the pixel data.

## Interface
- CLK_DIV, 4: system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels (H_TOTAL = 800)
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines (V_TOTAL = 525)
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- raddr  out  19  VRAM read address = v*H_ACTIVE + h; combinational from the counters
- data  in  8  VRAM read word, valid one clk after raddr
- vga_r  out  4  red; registered
- vga_g  out  4  green; registered
- vga_b  out  4  blue; registered, always 0
- hsync  out  1  horizontal sync, active-low; registered
- vsync  out  1  vertical sync, active-low; registered
- frame_start  out  1  one-clk pulse at the start of each frame

## Operation
- div counter: 0..CLK_DIV-1, wraps. pix_tick = (div == CLK_DIV-1).
- h counter: 0..H_TOTAL-1. Increments on pix_tick and wraps to 0.
- v counter: 0..V_TOTAL-1. Increments on pix_tick only when h wraps. Wraps to 0 after V_TOTAL-1.
- active = (h < H_ACTIVE) && (v < V_ACTIVE).
- raddr:
  - raddr = v*640 + h, computed as (v<<9)+(v<<7)+h in 19 bits, whenever active.
  - raddr = 0 when not active.
  - Max value is 307199 at (639,479). No overflow is possible.
- Output registers load only on pix_tick:
  - vga_r <= active ? data[7:4] : 0
  - vga_g <= active ? data[3:0] : 0
  - vga_b <= 0
  - hsync <= !(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for h in 656..751
  - vsync <= !(v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for v in 490..491
- A lit VRAM bit returns data = 8'hFC, giving R=F, G=C, B=0 (amber).
- frame_start is registered. It is high for exactly one clk after the pix_tick edge at which (h,v) wraps from (799,524) to (0,0).
- Control is purely counter-based. There are no FSM states beyond the counters, and no backpressure or handshake.

## Timing
- Reset (async assert, sync release):
  - div, h, v = 0, so raddr = 0
  - vga_r, vga_g, vga_b = 0
  - hsync = vsync = 1
  - frame_start = 0
- The first pix_tick occurs CLK_DIV clks after reset release.
- Read latency:
  - raddr for (h,v) is stable for CLK_DIV clks.
  - The VRAM returns data after 1 clk, so data is valid by the pix_tick edge because CLK_DIV >= 2.
- Output latency:
  - Pins carry pixel (h,v) during the pixel period after the counters leave (h,v), i.e. CLK_DIV clks after raddr is first presented.
  - hsync and vsync carry the same one-pixel delay, so all outputs stay mutually aligned.
- Periods:
  - Line = 800*CLK_DIV clks = 3200.
  - Frame = 800*525*CLK_DIV clks = 1,680,000; frame_start pulses are exactly this far apart.
- Boundaries:
  - h wrap and v increment happen on the same pix_tick edge.
  - At the (799,524) wrap, h, v and frame_start all update on one edge.
- Reset mid-frame:
  - All outputs return to their reset values immediately.
  - The new frame restarts at (0,0); no partial-line recovery.
- Inputs:
  - data is sampled only on pix_tick.
  - data changes between ticks have no effect on the outputs.

## Test plan
- Reset: assert rst mid-line with data=8'hFC -> immediately vga_r/g/b=0, hsync=vsync=1, raddr=0, frame_start=0. After release, first pix_tick is 4 clks later.
- Horizontal timing: hold data=8'hFC -> per line, RGB=F/C/0 for 640 pixel periods (2560 clks) then 0. hsync falls 656 pixel periods after line start and stays low 96 (384 clks). Line period is 3200 clks.
- Vertical timing and frame pulse: vsync low for exactly 2 lines (6400 clks), starting at line 490. Consecutive frame_start pulses are 1,680,000 clks apart, each 1 clk wide.
- Addressing: sample raddr at (0,0)=0, (639,0)=639, (0,1)=640, (639,479)=307199. raddr=0 at h=640..799 and for v>=480.
- Pixel alignment: model VRAM with a single lit bit at (5,2) -> RGB=F/C/0 for exactly one pixel period (4 clks), appearing when the counters read (6,2). All other pixels are 0.
- Blanking override: data forced to 8'hFC during h>=640 or v>=480 -> RGB stays 0 throughout blanking.
